// File: rtl/UART_MIKE_pkg.sv
// Shared types for the UART receive deframer: parity modes, FSM states,
// and the FIFO entry layout. UART_DATA_MAX is the widest character any
// deframer built on this package can carry.
package UART_MIKE_pkg;

    localparam int UART_DATA_MAX = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } uart_parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_e;

    typedef struct packed {
        logic [UART_DATA_MAX-1:0] data;
        logic                     perr;
        logic                     ferr;
    } uart_rx_entry_s;

    // The register encoding 11 also means "no parity".
    function automatic uart_parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO. The head entry is a register loaded from the
// next read address (or bypassed from the write port), so it is valid in the
// cycle after a push and refills without a bubble after a pop. A push while
// full (without a simultaneous pop) is dropped and flagged on overrun.
module uart_rx_fifo
    import UART_MIKE_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = uart_rx_entry_s
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   ready,
    output entry_t head,
    output logic   valid,
    output logic   overrun
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    entry_t          head_reg;
    logic            overrun_reg;
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic [AW:0]     wr_ptr_next;
    logic [AW:0]     rd_ptr_next;
    logic            full;
    logic            empty;
    logic            pop;
    logic            accept;

    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop    = ready && !empty;
    assign accept = push && (!full || pop);

    assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, accept};
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointers, registered head entry and the overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            head_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            overrun_reg <= push && full && !pop;
            if (wr_ptr_next == rd_ptr_next) begin
                head_reg <= '0;
            end else if (accept && (wr_ptr_reg == rd_ptr_next)) begin
                head_reg <= push_data;
            end else begin
                head_reg <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    assign head    = head_reg;
    assign valid   = !empty;
    assign overrun = overrun_reg;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start/data/parity/stop FSM feeding a
// show-ahead FIFO. Build option UART_RX_MAJORITY_VOTE_EN selects a 2-of-3
// vote around mid-bit (decision one tick later) instead of a single sample.
// DATA_MAX must not exceed UART_DATA_MAX from the package.
module uart_rx_deframer
    import UART_MIKE_pkg::*;
#(
    parameter int DATA_MAX   = 9,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                rx,
    input  logic [3:0]          cfg_data_bits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    output logic [DATA_MAX-1:0] rx_data,
    output logic                rx_perr,
    output logic                rx_ferr,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                overrun,
    output logic                busy
);

    localparam int             CW       = $clog2(OVS);
    localparam logic [CW-1:0]  LAST_CNT = CW'(OVS - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0]  START_DEC = CW'(OVS / 2 + 1);
`else
    localparam logic [CW-1:0]  START_DEC = CW'(OVS / 2);
`endif
    localparam logic [3:0]     BITS_MAX = 4'(DATA_MAX);
    localparam logic [3:0]     BITS_MIN = 4'd5;

    uart_rx_state_e  state_reg, state_next;
    logic [CW-1:0]   ovs_cnt_reg, ovs_cnt_next;
    logic [3:0]      bit_cnt_reg, bit_cnt_next;
    logic [3:0]      data_bits_reg, data_bits_next;
    uart_parity_e    parity_reg, parity_next;
    logic            stop2_reg, stop2_next;
    logic            stop_cnt_reg, stop_cnt_next;
    logic            perr_reg, perr_next;
    logic            ferr_reg, ferr_next;
    logic            shreg_clear;
    logic            shreg_capture;
    logic [DATA_MAX-1:0] shreg;
    logic            bit_value;
    logic            mid_tick;
    logic            push;
    uart_rx_entry_s  push_entry;
    uart_rx_entry_s  fifo_head;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_reg;

    // Remember the two previous tick samples so the decision tick can vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= 2'b11;
        end else if (sample_tick) begin
            hist_reg <= {hist_reg[0], rx};
        end
    end

    assign bit_value = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx) | (hist_reg[0] & rx);
`else
    assign bit_value = rx;
`endif

    // After the start decision the counter is realigned so that every later
    // decision lands exactly OVS ticks after the previous one.
    assign mid_tick = (ovs_cnt_reg == LAST_CNT);

    // State and frame-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ovs_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            data_bits_reg <= BITS_MIN;
            parity_reg    <= PAR_NONE;
            stop2_reg     <= 1'b0;
            stop_cnt_reg  <= 1'b0;
            perr_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ovs_cnt_reg   <= ovs_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            data_bits_reg <= data_bits_next;
            parity_reg    <= parity_next;
            stop2_reg     <= stop2_next;
            stop_cnt_reg  <= stop_cnt_next;
            perr_reg      <= perr_next;
            ferr_reg      <= ferr_next;
        end
    end

    // Next-state logic; only sample ticks advance the frame.
    always_comb begin
        state_next     = state_reg;
        ovs_cnt_next   = ovs_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        data_bits_next = data_bits_reg;
        parity_next    = parity_reg;
        stop2_next     = stop2_reg;
        stop_cnt_next  = stop_cnt_reg;
        perr_next      = perr_reg;
        ferr_next      = ferr_reg;
        shreg_clear    = 1'b0;
        shreg_capture  = 1'b0;
        if (sample_tick) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!rx) begin
                        state_next   = ST_START;
                        ovs_cnt_next = CW'(1);
                        if (cfg_data_bits > BITS_MAX) begin
                            data_bits_next = BITS_MAX;
                        end else if (cfg_data_bits < BITS_MIN) begin
                            data_bits_next = BITS_MIN;
                        end else begin
                            data_bits_next = cfg_data_bits;
                        end
                        parity_next = decode_parity(cfg_parity);
                        stop2_next  = cfg_stop2;
                        perr_next   = 1'b0;
                        ferr_next   = 1'b0;
                    end
                end
                ST_START: begin
                    if (ovs_cnt_reg == START_DEC) begin
                        ovs_cnt_next = '0;
                        if (bit_value) begin
                            state_next = ST_IDLE;
                        end else begin
                            state_next   = ST_DATA;
                            shreg_clear  = 1'b1;
                            bit_cnt_next = '0;
                        end
                    end else begin
                        ovs_cnt_next = ovs_cnt_reg + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (mid_tick) begin
                        ovs_cnt_next  = '0;
                        shreg_capture = 1'b1;
                        bit_cnt_next  = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == data_bits_reg - 4'd1) begin
                            stop_cnt_next = 1'b0;
                            state_next    = (parity_reg != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        ovs_cnt_next = ovs_cnt_reg + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (mid_tick) begin
                        ovs_cnt_next  = '0;
                        perr_next     = ((^shreg) ^ bit_value) != (parity_reg == PAR_ODD);
                        stop_cnt_next = 1'b0;
                        state_next    = ST_STOP;
                    end else begin
                        ovs_cnt_next = ovs_cnt_reg + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (mid_tick) begin
                        ovs_cnt_next = '0;
                        if (!bit_value) begin
                            ferr_next = 1'b1;
                        end
                        if (stop_cnt_reg == stop2_reg) begin
                            state_next = ST_IDLE;
                        end else begin
                            stop_cnt_next = 1'b1;
                        end
                    end else begin
                        ovs_cnt_next = ovs_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs: busy flag and the push of a finished character.
    always_comb begin
        busy                           = (state_reg != ST_IDLE);
        push                           = 1'b0;
        push_entry                     = '0;
        push_entry.data[DATA_MAX-1:0]  = shreg;
        push_entry.perr                = perr_reg;
        push_entry.ferr                = ferr_reg | ~bit_value;
        if (sample_tick && (state_reg == ST_STOP) && mid_tick && (stop_cnt_reg == stop2_reg)) begin
            push = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_MAX; gi++) begin : g_shreg
            logic bit_reg;

            // One character bit, written only when bit_cnt points at it.
            always_ff @(posedge clk) begin
                if (rst || shreg_clear) begin
                    bit_reg <= 1'b0;
                end else if (shreg_capture && (bit_cnt_reg == 4'(gi))) begin
                    bit_reg <= bit_value;
                end
            end

            assign shreg[gi] = bit_reg;
        end
    endgenerate

    uart_rx_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (uart_rx_entry_s)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .ready     (rx_ready),
        .head      (fifo_head),
        .valid     (rx_valid),
        .overrun   (overrun)
    );

    assign rx_data = fifo_head.data[DATA_MAX-1:0];
    assign rx_perr = fifo_head.perr;
    assign rx_ferr = fifo_head.ferr;

endmodule
